// File: rtl/dmem_ctrl.sv
// Data-memory access controller: turns datapath load/store strobes into a
// req/ack transaction with a variable-latency word memory, stalling the core meanwhile.
module dmem_ctrl #(
  parameter int N       = 16,
  parameter int AW      = 16,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          memread,
  input  logic          memwrite,
  input  logic [AW-1:0] addr,
  input  logic [N-1:0]  wdata,
  output logic [N-1:0]  rdata,
  output logic          stall,
  output logic          err_align,
  output logic          err_timeout,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-2:0] mem_addr,
  output logic [N-1:0]  mem_wdata,
  input  logic [N-1:0]  mem_rdata,
  input  logic          mem_ack
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] cnt;
  logic          access;
  logic          accept;
  logic          misaligned;
  logic          timeout_hit;

  always_comb begin
    access      = memread | memwrite;
    accept      = (state == IDLE) && access && !addr[0];
    misaligned  = (state == IDLE) && access && addr[0];
    // Ack in the final allowed cycle takes priority over the timeout.
    timeout_hit = (state == BUSY) && !mem_ack && (cnt == CW'(TIMEOUT - 1));
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = BUSY;
      BUSY:    if (mem_ack || timeout_hit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Gated by reset so the core is released the instant reset asserts.
  always_comb begin
    stall   = reset && (accept || (state == BUSY));
    mem_req = (state == BUSY);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      rdata       <= '0;
      err_align   <= 1'b0;
      err_timeout <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        mem_addr  <= addr[AW-1:1];
        mem_wdata <= wdata;
        mem_we    <= memwrite;
        cnt       <= '0;
      end
      if (misaligned) err_align <= 1'b1;
      if (state == BUSY) begin
        if (mem_ack) begin
          if (!mem_we) rdata <= mem_rdata;
        end else begin
          if (cnt != CW'(TIMEOUT)) cnt <= cnt + CW'(1);
          if (timeout_hit) begin
            err_timeout <= 1'b1;
            if (!mem_we) rdata <= N'(16'hDEAD);
          end
        end
      end
    end
  end

endmodule
